// File: rtl/mips_pkg.sv
// mips_pkg: shared state encodings, opcode/funct constants and ALU control codes.
package mips_pkg;
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/aludec.sv
// aludec: maps the controller's aluop and the funct field to the ALU control word.
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);
  logic [2:0] fdec;
  always_comb
    fdec = funct == FN_SUB ? ALU_SUB :
           funct == FN_AND ? ALU_AND :
           funct == FN_OR  ? ALU_OR  :
           funct == FN_SLT ? ALU_SLT : ALU_ADD;
  assign alucont = aluop[1] ? fdec : aluop[0] ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/mips_controller.sv
// mips_controller: multicycle MIPS Moore control FSM driving datapath enables, muxes and ALU control.
module mips_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucont
);
  logic [3:0] state, nxt, s;
  logic [1:0] aluop;
  logic       mw, irw, rw, pcwrite, branch;
  always_ff @(posedge clk)
    state <= reset ? S_FETCH : nxt;
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:   nxt = S_DECODE;
      S_DECODE:  nxt = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                       op == OP_RTYPE ? S_RTYPEEX :
                       op == OP_BEQ   ? S_BEQEX   :
                       op == OP_ADDI  ? S_ADDIEX  :
                       op == OP_J     ? S_JEX     : S_FETCH;
      S_MEMADR:  nxt = op == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:   nxt = S_MEMWB;
      S_RTYPEEX: nxt = S_RTYPEWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      default:   nxt = S_FETCH;
    endcase
  end
  // during reset the mux selects already show FETCH values
  assign s = reset ? S_FETCH : state;
  always_comb begin
    mw = 1'b0;
    iord = 1'b0;
    irw = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    rw = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    pcwrite = 1'b0;
    branch = 1'b0;
    aluop = 2'b00;
    case (s)
      S_FETCH:   begin irw = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB:   begin memtoreg = 1'b1; rw = 1'b1; end
      S_MEMWR:   begin iord = 1'b1; mw = 1'b1; end
      S_RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      S_RTYPEWB: begin regdst = 1'b1; rw = 1'b1; end
      S_BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
      S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_ADDIWB:  rw = 1'b1;
      S_JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default:   ;
    endcase
  end
  assign memwrite = mw & ~reset;
  assign irwrite  = irw & ~reset;
  assign regwrite = rw & ~reset;
  assign pcen     = ~reset & (pcwrite | (branch & zero));
  aludec u_aludec (.aluop(aluop), .funct(funct), .alucont(alucont));
endmodule

// File: tb/tb_mips_controller.sv
// tb_mips_controller: directed per-cycle expectations pushed to a scoreboard, checked by a negedge monitor.
module tb_mips_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       zero = 1'b0;
  logic       memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;
  int tests = 0, fails = 0;
  typedef struct { string name; logic [15:0] e; } exp_t;
  exp_t q[$];
  bit done = 1'b0;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucont(alucont)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] v(input logic mw, io, irw, rd, m2r, rw, asa,
                                    input logic [1:0] asb, pcs, input logic pe,
                                    input logic [2:0] alu);
    return {mw, io, irw, rd, m2r, rw, asa, asb, pcs, pe, alu};
  endfunction

  logic [15:0] got;
  assign got = {memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucont};

  localparam logic [15:0] F  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,3'b010};
  localparam logic [15:0] RS = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,3'b010};
  localparam logic [15:0] D  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,3'b010};
  localparam logic [15:0] MA = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,3'b010};
  localparam logic [15:0] MR = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,3'b010};
  localparam logic [15:0] MB = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,3'b010};
  localparam logic [15:0] SW = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,3'b010};
  localparam logic [15:0] RW = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,3'b010};
  localparam logic [15:0] AW = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,3'b010};
  localparam logic [15:0] JX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,3'b010};

  task automatic step(input string name, input logic r, input logic [5:0] o, f,
                      input logic z, input logic [15:0] e);
    @(posedge clk);
    #1;
    reset = r; op = o; funct = f; zero = z;
    q.push_back('{name, e});
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        x = q.pop_front();
        tests++;
        if (got !== x.e) begin
          fails++;
          $display("FAIL %s: got %b required %b", x.name, got, x.e);
        end
      end
    end
  end

  initial begin : stim
    logic [5:0] fn [6];
    logic [2:0] al [6];
    fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    al = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    step("reset0", 1, 0, 0, 0, RS);
    step("fetch0", 0, 6'b000000, 6'b100000, 0, F);
    step("rt_dec", 0, 6'b000000, 6'b100000, 0, D);
    step("rt_ex_rst1", 1, 6'b000000, 6'b100000, 1, RS);
    step("rst2", 1, 6'b000000, 6'b100000, 1, RS);
    step("rst3", 1, 6'b000000, 6'b100000, 1, RS);
    step("rel_fetch", 0, 6'b100011, 0, 1, F);
    step("lw_dec", 0, 6'b100011, 0, 1, D);
    step("lw_memadr", 0, 6'b100011, 0, 1, MA);
    step("lw_memrd", 0, 6'b100011, 0, 1, MR);
    step("lw_memwb", 0, 6'b100011, 0, 1, MB);
    step("sw_fetch", 0, 6'b101011, 0, 0, F);
    step("sw_dec", 0, 6'b101011, 0, 0, D);
    step("sw_memadr", 0, 6'b101011, 0, 0, MA);
    step("sw_memwr", 0, 6'b101011, 0, 0, SW);
    for (int i = 0; i < 6; i++) begin
      step("rt_fetch", 0, 6'b000000, fn[i], 0, F);
      step("rt_dec", 0, 6'b000000, fn[i], 0, D);
      step($sformatf("rt_ex_fn%b", fn[i]), 0, 6'b000000, fn[i], 0,
           v(0,0,0,0,0,0,1,2'b00,2'b00,0,al[i]));
      step("rt_wb", 0, 6'b000000, fn[i], 0, RW);
    end
    for (int z = 1; z >= 0; z--) begin
      step("beq_fetch", 0, 6'b000100, 0, 1'(z), F);
      step("beq_dec", 0, 6'b000100, 0, 1'(z), D);
      step($sformatf("beq_ex_z%0d", z), 0, 6'b000100, 0, 1'(z),
           v(0,0,0,0,0,0,1,2'b00,2'b01,1'(z),3'b110));
    end
    step("addi_fetch", 0, 6'b001000, 0, 1, F);
    step("addi_dec", 0, 6'b001000, 0, 1, D);
    step("addi_ex", 0, 6'b001000, 0, 1, MA);
    step("addi_wb", 0, 6'b001000, 0, 1, AW);
    step("j_fetch", 0, 6'b000010, 0, 0, F);
    step("j_dec", 0, 6'b000010, 0, 0, D);
    step("j_ex", 0, 6'b000010, 0, 0, JX);
    step("ill_fetch", 0, 6'b111111, 0, 1, F);
    step("ill_dec", 0, 6'b111111, 0, 1, D);
    step("ill_back_fetch", 0, 6'b111111, 0, 1, F);
    step("after_ill_dec", 0, 6'b111111, 0, 0, D);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      tests++;
      $display("FAIL drain: %0d pending expectations required 0", q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle MIPS control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and muxes, and produces the 3-bit `alucont` word consumed by the datapath ALU. The design has one controller per core, sitting between the instruction register (`op`, `funct`) and the datapath, with the ALU `zero` flag fed back for branches.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  6  opcode field of the instruction register.
- `funct`  in  6  function field of the instruction register.
- `zero`  in  1  ALU result equals zero.
- `memwrite`  out  1  memory write enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU output register.
- `irwrite`  out  1  instruction register load enable.
- `regdst`  out  1  destination register select: 0 = rt, 1 = rd.
- `memtoreg`  out  1  writeback data select: 0 = ALU output register, 1 = memory data register.
- `regwrite`  out  1  register file write enable.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALU output register, 10 = jump target.
- `pcen`  out  1  PC write enable.
- `alucont`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- **Transitions:**
  - FETCH→DECODE unconditionally.
  - DECODE→MEMADR (lw 100011, sw 101011), RTYPEEX (000000), BEQEX (000100), ADDIEX (001000), JEX (000010).
  - DECODE→FETCH for any other opcode; the illegal instruction is a no-op.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB; RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX → FETCH.
- **Outputs per state** (unlisted signals are 0, `aluop`=00):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- **PC enable:** `pcen` = pcwrite | (branch & zero).
- **ALU decode** (`aluop`, internal 2 bits):
  - 00→010; 01→110.
  - 10→funct decode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other funct→010.

## Timing
- Outputs are combinational decodes of the state register only; `zero` affects only `pcen`. No input-to-state bypass.
- Cycles per instruction, counted from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset: the state register loads FETCH on any rising edge where `reset`=1, which aborts any in-flight instruction.
- While `reset`=1, `memwrite`, `irwrite`, `regwrite` and `pcen` are forced to 0. The other outputs show their FETCH values (alusrcb=01, `alucont`=010, all else 0).
- On the first edge after `reset` deasserts, the FETCH enables take effect.
- `zero` is sampled only in BEQEX, within the same cycle. Its value in every other state is ignored.
- `op` and `funct` are sampled in DECODE, MEMADR and RTYPEEX. The instruction register is held stable because `irwrite`=0 outside FETCH.

## Structure
- Shared package `mips_pkg`:
  - state encoding localparams (4-bit, binary);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - `alucont` codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT).
- Sub-module `aludec`: combinational (`aluop`, `funct`) → `alucont`. It is instantiated once and is reusable by a single-cycle variant.
- Top: state register, next-state logic, output decode, `pcen` logic.

## Test plan
- Reset held 3 cycles mid-RTYPEEX → state FETCH; `pcen`, `regwrite`, `memwrite`, `irwrite` all 0 while `reset` is high; `irwrite`=1 and `pcen`=1 in the first cycle after release.
- lw (op=100011) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; `iord`=1 in MEMRD; `memtoreg`=1, `regwrite`=1 and `regdst`=0 in MEMWB.
- sw (op=101011) → 4 cycles; `memwrite`=1 only in MEMWR; `regwrite` never 1.
- R-type, funct sweeping 100000/100010/100100/100101/101010 → `alucont` in RTYPEEX equals 010/110/000/001/111; funct 000111 gives 010; `regdst`=1 in RTYPEWB.
- beq (op=000100) with `zero`=1 → `pcen`=1, `pcsrc`=01, `alucont`=110 in BEQEX; with `zero`=0 → `pcen`=0; 3 cycles either way.
- j (op=000010) → `pcen`=1 and `pcsrc`=10 in JEX. Illegal op=111111 → DECODE then FETCH, with no write enables asserted in DECODE.
